// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

  typedef logic [RF_XLEN-1:0] rf_word_t;

endpackage

// File: rtl/rf_bank.sv
// One NREGS x XLEN register bank: single write port, single synchronous read
// port with read enable. Read-first on a same-cycle write to the read address.
module rf_bank
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  localparam int AW   = addr_w(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            re,
  input  logic [AW-1:0]   ra,
  output logic [XLEN-1:0] rd
);

  logic [XLEN-1:0] mem [NREGS];

  // NOTE: no reset on the array or its read register so the tools can map this
  // onto block RAM; the top clears contents with a sweep and masks rd until valid.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: clear sweep after reset, 1-cycle read, x0 = 0.
// Define REGFILE_BYPASS_EN for write-first behaviour on same-cycle write/read.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = 2,
  localparam int AW   = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  stall,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  output logic                  init_done
);

  rf_state_e           state_q, state_d;
  logic [AW-1:0]       clr_ptr_q;
  logic [NREAD*AW-1:0] ra_q;
  logic                rd_valid_q;
  logic                init_done_q;
  logic                data_ok_q;   // a read has completed since reset

  logic            run;
  logic            rd_acc;
  logic            bank_we;
  logic [AW-1:0]   bank_wa;
  logic [XLEN-1:0] bank_wd;

  assign run    = (state_q == RF_RUN);
  assign rd_acc = rd_req & run;

  // The sweep owns the shared write port while clearing; external writes drop.
  assign bank_we = ~run | (we & (wa != '0));
  assign bank_wa = run ? wa : clr_ptr_q;
  assign bank_wd = run ? wd : '0;

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == RF_CLEAR && clr_ptr_q == AW'(NREGS - 1)) state_d = RF_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RF_CLEAR;
      clr_ptr_q   <= '0;
      ra_q        <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      data_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == RF_RUN);
      rd_valid_q  <= rd_acc;
      if (!run) clr_ptr_q <= clr_ptr_q + AW'(1);
      if (rd_acc) begin
        ra_q      <= ra;
        data_ok_q <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [NREAD-1:0] byp_q;
  logic [XLEN-1:0]  byp_wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q    <= '0;
      byp_wd_q <= '0;
    end else if (rd_acc) begin
      byp_wd_q <= wd;
      for (int i = 0; i < NREAD; i++)
        byp_q[i] <= we && (wa != '0) && (wa == ra[i*AW +: AW]);
    end
  end
`endif

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    logic [XLEN-1:0] bank_rd;
    logic [XLEN-1:0] word;

    rf_bank #(.XLEN(XLEN), .NREGS(NREGS)) u_bank (
      .clk (clk),
      .we  (bank_we),
      .wa  (bank_wa),
      .wd  (bank_wd),
      .re  (rd_acc),
      .ra  (ra[g*AW +: AW]),
      .rd  (bank_rd)
    );

`ifdef REGFILE_BYPASS_EN
    assign word = byp_q[g] ? byp_wd_q : bank_rd;
`else
    assign word = bank_rd;
`endif

    // Bank output is unreset, so present 0 until the first read completes.
    assign rd_data[g*XLEN +: XLEN] =
      (data_ok_q && (ra_q[g*AW +: AW] != '0)) ? word : '0;
  end

  assign rd_valid  = rd_valid_q;
  assign init_done = init_done_q;
  assign stall     = ~run | rd_req;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (XLEN=32, NREGS=32, NREAD=2): vector table plus
// hand-written sequences for the clear sweep and reset during a read.
module tb_regfile_mp;
  import rf_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [9:0]  ra;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        we;
  logic [4:0]  wa;
  rf_word_t    wd;
  logic        init_done;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .ra        (ra),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .stall     (stall),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd_req;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        exp_valid;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                              input logic r, input logic [4:0] r0, input logic [4:0] r1,
                              input logic ev, input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.rd_req = r; v.ra0 = r0; v.ra1 = r1;
    v.exp_valid = ev; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1);
    rd_req = 1'b1;
    ra     = {a1, a0};
    @(posedge clk); #1;
    rd_req = 1'b0;
    check({name, "_valid"}, 64'(rd_valid), 64'd1);
    check({name, "_data"}, rd_data, {e1, e0});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Returns the number of cycles until init_done rises (bounded at 100).
  task automatic wait_init(output int n, output logic saw_valid, output logic stall_low);
    n = 0; saw_valid = 1'b0; stall_low = 1'b0;
    while (!init_done && n < 100) begin
      if (!stall) stall_low = 1'b1;
      @(posedge clk); #1;
      n++;
      if (rd_valid) saw_valid = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [20];
    logic [63:0] last;
    int          n;
    logic        saw_v, st_low;

    rst_n = 1'b0; rd_req = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_stall", 64'(stall), 64'd1);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;

    wait_init(n, saw_v, st_low);
    check("init_cycles", 64'(n), 64'd32);
    check("init_stall_held", 64'(st_low), 64'd0);

    for (int i = 0; i < 32; i += 2)
      rd_chk("zero_read", 5'(i), 5'(i + 1), 32'd0, 32'd0);

    tbl[0]  = mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[1]  = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tbl[2]  = mk(1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[3]  = mk(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[4]  = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);
    tbl[5]  = mk(1'b1, 5'd7, 32'h1,         1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[6]  = mk(1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[7]  = mk(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 5'd3, 1'b1,
                 BYP ? 32'hA5A5_A5A5 : 32'h1, 32'h3333_3333);
    tbl[8]  = mk(1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[9]  = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd7, 5'd3, 1'b1, 32'hA5A5_A5A5, 32'hCAFE_F00D);
    tbl[10] = mk(1'b1, 5'd1, 32'd10,        1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[11] = mk(1'b1, 5'd2, 32'd20,        1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[12] = mk(1'b1, 5'd3, 32'd30,        1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[13] = mk(1'b1, 5'd4, 32'd40,        1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[14] = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd1, 5'd2, 1'b1, 32'd10, 32'd20);
    tbl[15] = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd3, 5'd4, 1'b1, 32'd30, 32'd40);
    tbl[16] = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd4, 5'd1, 1'b1, 32'd40, 32'd10);
    tbl[17] = mk(1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tbl[18] = mk(1'b1, 5'd2, 32'h22,        1'b1, 5'd1, 5'd2, 1'b1,
                 32'd10, BYP ? 32'h22 : 32'd20);
    tbl[19] = mk(1'b0, 5'd0, 32'd0,         1'b1, 5'd2, 5'd2, 1'b1, 32'h22, 32'h22);

    last = 64'd0;
    for (int i = 0; i < 20; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      rd_req = tbl[i].rd_req; ra = {tbl[i].ra1, tbl[i].ra0};
      #1;
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].rd_req));
      @(posedge clk); #1;
      if (tbl[i].exp_valid) last = {tbl[i].exp1, tbl[i].exp0};
      check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
      check($sformatf("vec%0d_data", i), rd_data, last);
    end
    we = 1'b0; rd_req = 1'b0;

    // Reset in the middle of a read, then external traffic during the sweep.
    wr(5'd9, 32'h99);
    rd_chk("r9_before_rst", 5'd9, 5'd9, 32'h99, 32'h99);
    rd_req = 1'b1; ra = {5'd9, 5'd9};
    @(posedge clk); #1;
    check("mid_read_valid", 64'(rd_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_valid", 64'(rd_valid), 64'd0);
    check("rst_clears_data", rd_data, 64'd0);
    check("rst_init_done_low", 64'(init_done), 64'd0);
    we = 1'b1; wa = 5'd9; wd = 32'hFFFF_FFFF;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init(n, saw_v, st_low);
    we = 1'b0; rd_req = 1'b0;
    check("reinit_cycles", 64'(n), 64'd32);
    check("sweep_no_valid", 64'(saw_v), 64'd0);
    check("sweep_stall_held", 64'(st_low), 64'd0);
    rd_chk("r9_after_sweep", 5'd9, 5'd5, 32'd0, 32'd0);
    rd_chk("r7_r2_after_sweep", 5'd7, 5'd2, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("final_valid_low", 64'(rd_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
